// File: rtl/bus_initiator_ctrl.sv
// -----------------------------------------------------------------------------
// bus_initiator_ctrl
//
// CPU-side initiator for the shared addr/data_write/data_read/write_en/read_en/
// ack bus. It takes one read or write command at a time and drives the bus
// strobes until the responder acks or the timeout expires. It then presents
// the result on a response port and holds it until the response is consumed.
//
// Ports
//   clk, rst          clock (posedge) and synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_ready is high only in IDLE
//   cmd_write         1 = write, 0 = read
//   cmd_addr          byte address; must be aligned to the bus word size
//   cmd_wdata         write data
//   rsp_valid/ready   response handshake; the response is held until consumed
//   rsp_rdata         read data; 0 for writes and for errors
//   rsp_error         misaligned address or timeout
//   bus_*             shared-bus signals toward the memory-side responder
// -----------------------------------------------------------------------------
module bus_initiator_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_write,
    input  logic [DATA_W-1:0] bus_data_read,
    output logic              bus_write_en,
    output logic              bus_read_en,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    // Low address bits that select a byte inside one bus word.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             misaligned;

    assign cmd_ready  = (state == IDLE);
    assign misaligned = |(cmd_addr & ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
            bus_addr       <= '0;
            bus_data_write <= '0;
            bus_write_en   <= 1'b0;
            bus_read_en    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (misaligned) begin
                            // Rejected without ever touching the bus.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state          <= REQ;
                            tmo_cnt        <= '0;
                            bus_addr       <= cmd_addr;
                            bus_data_write <= cmd_wdata;
                            bus_write_en   <= cmd_write;
                            bus_read_en    <= !cmd_write;
                        end
                    end
                end

                REQ: begin
                    // Ack wins over an expiry in the same cycle.
                    if (bus_ack) begin
                        state        <= RESP;
                        bus_write_en <= 1'b0;
                        bus_read_en  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b0;
                        rsp_rdata    <= bus_read_en ? bus_data_read : '0;
                    end else if (tmo_cnt == CNT_LAST) begin
                        state        <= RESP;
                        bus_write_en <= 1'b0;
                        bus_read_en  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b1;
                        rsp_rdata    <= '0;
                    end else if (tmo_cnt != CNT_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_initiator_ctrl.sv
module tb_bus_initiator_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] bus_addr;
    logic [63:0] bus_data_write;
    logic [63:0] bus_data_read;
    logic        bus_write_en;
    logic        bus_read_en;
    logic        bus_ack;

    int passed = 0;
    int total  = 0;

    // Observations gathered by do_cmd.
    int          wr_w;
    int          rd_w;
    int          got_rsp;
    logic [31:0] addr_s;
    logic [63:0] data_s;

    bus_initiator_ctrl #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .bus_addr       (bus_addr),
        .bus_data_write (bus_data_write),
        .bus_data_read  (bus_data_read),
        .bus_write_en   (bus_write_en),
        .bus_read_en    (bus_read_en),
        .bus_ack        (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one command at a negedge and act as responder: ack is raised during
    // the ack_at-th cycle the strobe is high (0 = never ack). Returns at the
    // first negedge where rsp_valid is seen, or after a 40-cycle bound.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                          input int ack_at, input logic [63:0] rdata_in);
        @(negedge clk);
        check("cmd_ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_w = 0; rd_w = 0; got_rsp = 0; addr_s = '0; data_s = '0;
        for (int i = 0; i < 40; i++) begin
            bus_ack = 1'b0;
            if (rsp_valid) begin
                got_rsp = 1;
                break;
            end
            if (bus_write_en) wr_w++;
            if (bus_read_en)  rd_w++;
            if ((wr_w + rd_w) == 1 && (bus_write_en || bus_read_en)) begin
                addr_s = bus_addr;
                data_s = bus_data_write;
            end
            if ((bus_write_en || bus_read_en) && (wr_w + rd_w) == ack_at) begin
                bus_ack       = 1'b1;
                bus_data_read = rdata_in;
            end
            @(negedge clk);
        end
        bus_ack = 1'b0;
        check("rsp_arrived", 64'(got_rsp), 64'd1);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_clr"}, rsp_valid, 1'b0);
        check({tag, "_cmd_ready_ret"}, cmd_ready, 1'b1);
        check({tag, "_rsp_err_clr"},   rsp_error, 1'b0);
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; bus_data_read = '0; bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_write_en", bus_write_en, 1'b0);
        check("rst_read_en", bus_read_en, 1'b0);
        check("rst_bus_addr", bus_addr, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);

        // 1: write, ack in second strobe cycle
        do_cmd(1'b1, 32'h100, 64'hDEAD_BEEF, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_wr_width", 64'(wr_w), 64'd2);
        check("t1_rd_width", 64'(rd_w), 64'd0);
        check("t1_addr", 64'(addr_s), 64'h100);
        check("t1_wdata", data_s, 64'hDEAD_BEEF);
        check("t1_error", rsp_error, 1'b0);
        check("t1_rdata", rsp_rdata, 64'd0);
        check("t1_cmd_ready_busy", cmd_ready, 1'b0);
        check("t1_strobes_low", {bus_write_en, bus_read_en}, 2'b00);
        handshake("t1");
        check("t1_addr_held", 64'(bus_addr), 64'h100);

        // 2: read, ack in third strobe cycle
        do_cmd(1'b0, 32'h08, 64'h0, 3, 64'h1234_5678_9ABC_DEF0);
        check("t2_rd_width", 64'(rd_w), 64'd3);
        check("t2_wr_width", 64'(wr_w), 64'd0);
        check("t2_addr", 64'(addr_s), 64'h08);
        check("t2_error", rsp_error, 1'b0);
        check("t2_rdata", rsp_rdata, 64'h1234_5678_9ABC_DEF0);
        handshake("t2");

        // 3: misaligned read
        do_cmd(1'b0, 32'h0C, 64'h0, 1, 64'h5555_5555_5555_5555);
        check("t3_rd_width", 64'(rd_w), 64'd0);
        check("t3_wr_width", 64'(wr_w), 64'd0);
        check("t3_error", rsp_error, 1'b1);
        check("t3_rdata", rsp_rdata, 64'd0);
        handshake("t3");

        // 4a: read, no ack -> timeout after 16 strobe cycles
        do_cmd(1'b0, 32'h10, 64'h0, 0, 64'h0);
        check("t4a_rd_width", 64'(rd_w), 64'd16);
        check("t4a_error", rsp_error, 1'b1);
        check("t4a_rdata", rsp_rdata, 64'd0);
        handshake("t4a");

        // 4b: ack on the 16th cycle wins over expiry
        do_cmd(1'b0, 32'h18, 64'h0, 16, 64'hCAFE_F00D_0BAD_BEEF);
        check("t4b_rd_width", 64'(rd_w), 64'd16);
        check("t4b_error", rsp_error, 1'b0);
        check("t4b_rdata", rsp_rdata, 64'hCAFE_F00D_0BAD_BEEF);
        handshake("t4b");

        // 5: response back-pressure with a new command waiting
        do_cmd(1'b0, 32'h20, 64'h0, 1, 64'hA5A5_A5A5_5A5A_5A5A);
        check("t5_rd_width", 64'(rd_w), 64'd1);
        held = rsp_rdata;
        check("t5_rdata", held, 64'hA5A5_A5A5_5A5A_5A5A);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h28; cmd_wdata = 64'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", rsp_valid, 1'b1);
            check("t5_hold_rdata", rsp_rdata, held);
            check("t5_hold_cmd_ready", cmd_ready, 1'b0);
            check("t5_hold_strobes", {bus_write_en, bus_read_en}, 2'b00);
        end
        cmd_valid = 1'b0;
        handshake("t5");
        do_cmd(1'b1, 32'h28, 64'h77, 1, 64'h0);
        check("t5_next_wr_width", 64'(wr_w), 64'd1);
        check("t5_next_wdata", data_s, 64'h77);
        handshake("t5n");

        // 6: reset while in REQ, then a late ack
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t6_in_req", bus_read_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_strobes_after_rst", {bus_write_en, bus_read_en}, 2'b00);
        check("t6_rsp_valid_after_rst", rsp_valid, 1'b0);
        check("t6_cmd_ready_after_rst", cmd_ready, 1'b1);
        bus_ack = 1'b1; bus_data_read = 64'h1;
        repeat (2) @(negedge clk);
        bus_ack = 1'b0;
        check("t6_late_ack_rsp", rsp_valid, 1'b0);
        check("t6_late_ack_strobes", {bus_write_en, bus_read_en}, 2'b00);
        check("t6_late_ack_ready", cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
